interval_meter: RTL and testbench
=================================

Name: interval_meter

Overview:
- Measures elapsed time between a start event and a stop event, in units of PRESCALE clock cycles.
- Latches the result and flags a timeout if the stop event does not arrive within a programmable limit.
- It is the inverse of the countdown pulse timer: that block turns a time value into a pulse; this block turns a pulse interval into a time value.
- Used by game control to time player responses, e.g. button press after prompt, and to detect "player too slow".

Parameters:
- WIDTH, 25: width of count, limit and result.
- PRESCALE, 1: clock cycles per count unit. Must be ≥1. A prescaler of width clog2(PRESCALE) or 1 bit is used.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin or restart a measurement. Sampled each edge.
- stop  input  1  end the measurement. Sampled each edge.
- limit  input  WIDTH  timeout threshold in count units. Latched on an accepted start. 0 means no timeout.
- busy  output  1  high while a measurement is running.
- count  output  WIDTH  live elapsed count. Holds its last value when idle.
- result  output  WIDTH  latched measurement. Updated only on done or timeout.
- done  output  1  one-cycle pulse: stop was accepted and result is valid.
- timeout  output  1  one-cycle pulse: limit was reached before stop.

Behaviour:
- Reset (asynchronous, any time, including mid-measurement):
  - State goes to IDLE.
  - busy=0, count=0, result=0, done=0, timeout=0.
  - Prescaler=0, latched limit=0.
- States: IDLE and RUN. done and timeout are registered and default to 0 on every edge.
- IDLE:
  - start=1 at edge E0: enter RUN; count=0; prescaler=0; limit latched; busy=1 after E0.
  - stop alone is ignored. start and stop together: start is taken, stop is ignored.
- RUN, each edge, tick definition:
  - tick=1 when prescaler==PRESCALE-1. The prescaler then wraps to 0; otherwise it increments.
  - next_count = count+tick, saturating at all-ones (no wrap).
- RUN, priority of events within one edge (highest first):
  1. stop=1: result=next_count; done=1; enter IDLE; busy=0; count=next_count. The stop edge itself counts. start is ignored on this edge.
  2. start=1: restart. count=0; prescaler=0; limit relatched; no done or timeout; stays in RUN.
  3. latched limit≠0 and next_count==limit: result=limit; timeout=1; enter IDLE; count=limit.
  4. Otherwise: count=next_count.
- Timing consequences:
  - Start at E0 and stop at Em (m≥1) gives result=floor(m/PRESCALE).
  - With limit L≠0 and no stop, timeout pulses at edge E(L*PRESCALE). busy falls on the same edge.
  - stop on exactly that edge takes priority: done=1, result=L, timeout=0.
- Saturation: with limit=0, count stops at 2^WIDTH-1 and RUN continues until stop or start.
- done and timeout are never high in the same cycle. Neither fires in IDLE.
- Output latency: busy, count, result, done and timeout all change exactly one edge after the sampling edge of the causing input.

Test Plan:
- PRESCALE=1, limit=0: start at E0, stop at E5 → done=1 for one cycle after E5; result=5; busy 1→0 after E5.
- PRESCALE=4, limit=0: start at E0, stop at E10 → result=2 (floor 10/4). Repeat with stop at E12 → result=3.
- PRESCALE=1, limit=7, no stop: start at E0 → timeout pulse after E7; result=7; done stays 0; later stop is ignored.
- PRESCALE=1, limit=7: start at E0, stop at E7 → done=1, timeout=0, result=7 (stop beats timeout).
- Start at E0, restart with start at E3, stop at E8 → result=5. No done at E3; limit relatched at E3.
- WIDTH=3, limit=0, PRESCALE=1: run 12 cycles then stop → result=7 (saturated).
- Start, then assert reset asynchronously mid-run (between edges) → busy=0, count=0, result=0 immediately.
- Stop while IDLE → no done pulse and result unchanged.

Source files
------------

// File: rtl/interval_meter.sv
// Interval meter: counts prescaled ticks between a start and a stop event,
// latches the elapsed time, and pulses timeout if a non-zero limit is reached first.
module interval_meter #(
  parameter int WIDTH    = 25,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             timeout
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic             tick;
  logic [WIDTH-1:0] next_count;

  assign tick       = (pre_q == PS_LAST);
  // Saturate instead of wrapping so a very long wait never reads as short.
  assign next_count = (tick && (count_q != '1)) ? count_q + 1'b1 : count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
      limit_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      count_q   <= count_d;
      result_q  <= result_d;
      limit_q   <= limit_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    count_d   = count_q;
    result_d  = result_q;
    limit_d   = limit_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = '0;
          pre_d   = '0;
          limit_d = limit;
        end
      end
      S_RUN: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        // Stop outranks restart and timeout; the stop edge's own tick counts.
        if (stop) begin
          state_d  = S_IDLE;
          result_d = next_count;
          count_d  = next_count;
          done_d   = 1'b1;
        end else if (start) begin
          count_d = '0;
          pre_d   = '0;
          limit_d = limit;
        end else if ((limit_q != '0) && (next_count == limit_q)) begin
          state_d   = S_IDLE;
          result_d  = limit_q;
          count_d   = limit_q;
          timeout_d = 1'b1;
        end else begin
          count_d = next_count;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_RUN);
  assign count   = count_q;
  assign result  = result_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_interval_meter.sv
// Bench for interval_meter: table of measurement scenarios over three parameter
// sets, with expected events queued at start and checked when done/timeout fires.
module tb_interval_meter;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [24:0] lim;

  logic        busy1, done1, to1;
  logic [24:0] count1, result1;
  logic        busy4, done4, to4;
  logic [24:0] count4, result4;
  logic        busy3, done3, to3;
  logic [2:0]  count3, result3;

  always #5 clk = ~clk;

  interval_meter #(.WIDTH(25), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .limit(lim),
    .busy(busy1), .count(count1), .result(result1), .done(done1), .timeout(to1));
  interval_meter #(.WIDTH(25), .PRESCALE(4)) u4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .limit(lim),
    .busy(busy4), .count(count4), .result(result4), .done(done4), .timeout(to4));
  interval_meter #(.WIDTH(3), .PRESCALE(1)) u3 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .limit(lim[2:0]),
    .busy(busy3), .count(count3), .result(result3), .done(done3), .timeout(to3));

  int          sel;
  logic        o_busy, o_done, o_to;
  logic [24:0] o_count, o_result;

  always_comb begin
    o_busy = busy1; o_done = done1; o_to = to1; o_count = count1; o_result = result1;
    if (sel == 4) begin
      o_busy = busy4; o_done = done4; o_to = to4; o_count = count4; o_result = result4;
    end else if (sel == 3) begin
      o_busy = busy3; o_done = done3; o_to = to3;
      o_count = {22'd0, count3}; o_result = {22'd0, result3};
    end
  end

  typedef struct {
    int sel;   // which instance: 1, 4 (PRESCALE=4) or 3 (WIDTH=3)
    int lim;   // limit at E0
    int rs;    // restart edge (0 = none)
    int lim2;  // limit presented at restart
    int sp;    // stop edge (0 = none)
    int res;   // expected result
    bit to;    // expect timeout instead of done
    int edge_n;// edge at which the event fires
  } vec_t;

  typedef struct {
    int res;
    bit to;
    int edge_n;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; lim = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, got_e;
    bit   seen;
    sel   = v.sel;
    lim   = 25'(v.lim);
    start = 1'b1;
    e.res = v.res; e.to = v.to; e.edge_n = v.edge_n;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), 32'(o_busy), 1);
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      start = (k == v.rs);
      if (k == v.rs) lim = 25'(v.lim2);
      stop  = (k == v.sp);
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      if (o_done || o_to) begin
        seen  = 1'b1;
        got_e = sb_q.pop_front();
        chk($sformatf("v%0d exclusive", idx), 32'(o_done && o_to), 0);
        chk($sformatf("v%0d kind_timeout", idx), 32'(o_to), 32'(got_e.to));
        chk($sformatf("v%0d result", idx), 32'(o_result), got_e.res);
        chk($sformatf("v%0d count", idx), 32'(o_count), got_e.res);
        chk($sformatf("v%0d edge", idx), k, got_e.edge_n);
        chk($sformatf("v%0d busy_after_event", idx), 32'(o_busy), 0);
      end
    end
    if (!seen) begin
      chk($sformatf("v%0d event_within_budget", idx), 0, 1);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic edges_check_idle(input string name, input int n, input int exp_res);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      stop = 1'b0;
      chk($sformatf("%s done_%0d", name, k), 32'(o_done), 0);
      chk($sformatf("%s result_%0d", name, k), 32'(o_result), exp_res);
    end
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 0, 5,  5, 1'b0, 5};
    vecs[1] = '{4, 0, 0, 0, 10, 2, 1'b0, 10};
    vecs[2] = '{4, 0, 0, 0, 12, 3, 1'b0, 12};
    vecs[3] = '{1, 7, 0, 0, 0,  7, 1'b1, 7};
    vecs[4] = '{1, 7, 0, 0, 7,  7, 1'b0, 7};
    vecs[5] = '{1, 4, 3, 0, 8,  5, 1'b0, 8};
    vecs[6] = '{1, 0, 3, 3, 0,  3, 1'b1, 6};
    vecs[7] = '{3, 0, 0, 0, 12, 7, 1'b0, 12};
    vecs[8] = '{4, 2, 0, 0, 0,  2, 1'b1, 8};
    vecs[9] = '{4, 0, 0, 0, 3,  0, 1'b0, 3};

    sel = 1;
    do_reset();
    chk("rst busy", 32'(o_busy), 0);
    chk("rst count", 32'(o_count), 0);
    chk("rst result", 32'(o_result), 0);
    chk("rst done", 32'(o_done), 0);
    chk("rst timeout", 32'(o_to), 0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_vec(vecs[i], i);
    end

    // Stop after a timeout is ignored and result keeps the limit.
    do_reset();
    run_vec(vecs[3], 10);
    stop = 1'b1;
    edges_check_idle("post_timeout_stop", 3, 7);

    // Start and stop together in IDLE: start wins, no done.
    sel = 1; lim = '0; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle busy", 32'(o_busy), 1);
    chk("start_stop_idle done", 32'(o_done), 0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("start_stop_idle done_e1", 32'(o_done), 1);
    chk("start_stop_idle result", 32'(o_result), 1);

    // Stop while idle: nothing happens.
    stop = 1'b1;
    edges_check_idle("idle_stop", 3, 1);

    // Saturated live count keeps running state.
    do_reset();
    sel = 3; lim = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
    end
    chk("sat count", 32'(o_count), 7);
    chk("sat busy", 32'(o_busy), 1);

    // Async reset mid-run clears everything before the next edge.
    do_reset();
    sel = 1; lim = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      stop = (k == 4);
      @(posedge clk); #1;
      stop = 1'b0;
    end
    chk("pre_areset result", 32'(o_result), 4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_areset live_count", 32'(o_count), 3);
    #2 reset = 1'b1;
    #1;
    chk("areset busy", 32'(o_busy), 0);
    chk("areset count", 32'(o_count), 0);
    chk("areset result", 32'(o_result), 0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
